// File: rtl/popcnt_acc_pkg.sv
// Shared FSM state encoding and default widths for the popcount accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package popcnt_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int IN_W_DEF  = 2;
   localparam int LEN_W_DEF = 6;
   localparam int ACC_W_DEF = 8;

endpackage

// File: rtl/popcnt_acc_if.sv
// Handshake bundle between the mismatch stage / result consumer and popcnt_acc.
// Latency: n/a (wires only). Optional thresh/act_out under POPCNT_ACC_THRESH_EN.
// Backpressure: out_ready from the consumer holds the result; beats have no ready.
interface popcnt_acc_if #(
   parameter int IN_W  = popcnt_acc_pkg::IN_W_DEF,
   parameter int LEN_W = popcnt_acc_pkg::LEN_W_DEF,
   parameter int ACC_W = popcnt_acc_pkg::ACC_W_DEF
) ();
   logic             start;
   logic [LEN_W-1:0] len;
   logic [IN_W-1:0]  op_in;
   logic             op_valid;
   logic             busy;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
`ifdef POPCNT_ACC_THRESH_EN
   logic [ACC_W-1:0] thresh;
   logic             act_out;
`endif

   // Producer/consumer side.
   modport master (
`ifdef POPCNT_ACC_THRESH_EN
      output thresh,
      input  act_out,
`endif
      output start, len, op_in, op_valid, out_ready,
      input  busy, acc_out, out_valid
   );

   // Accumulator side.
   modport slave (
`ifdef POPCNT_ACC_THRESH_EN
      input  thresh,
      output act_out,
`endif
      input  start, len, op_in, op_valid, out_ready,
      output busy, acc_out, out_valid
   );
endinterface

// File: rtl/popcnt_acc_vec.sv
// Combinational popcount of an IN_W-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module popcnt_vec #(
   parameter int IN_W  = popcnt_acc_pkg::IN_W_DEF,
   parameter int CNT_W = $clog2(IN_W + 1)
) (
   input  logic [IN_W-1:0]  vec_i,
   output logic [CNT_W-1:0] cnt_o
);

   // Sum of set bits.
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < IN_W; i++) begin
         cnt_o = cnt_o + CNT_W'(vec_i[i]);
      end
   end

endmodule

// File: rtl/popcnt_acc.sv
// Saturating mismatch-count accumulator for one binary dot-product (IDLE/ACC/DONE).
// Latency: result valid exactly 1 cycle after the last accepted beat; optional threshold via POPCNT_ACC_THRESH_EN.
// Backpressure: result held in DONE until out_ready; beats are not backpressured and are dropped outside ACC.
module popcnt_acc
   import popcnt_acc_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   popcnt_acc_if.slave  io
);

   localparam int CNT_W = $clog2(IN_W + 1);
   // One extra bit over the wider operand so the overflow is visible before clamping.
   localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
   localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [ACC_W-1:0]  acc_out_q, acc_out_d;
`ifdef POPCNT_ACC_THRESH_EN
   logic [ACC_W-1:0]  thresh_q, thresh_d;
   logic              act_q, act_d;
`endif

   logic [CNT_W-1:0]  beat_cnt;
   logic [SUM_W-1:0]  sum_wide;
   logic [ACC_W-1:0]  acc_sat;

   popcnt_vec #(
      .IN_W  (IN_W),
      .CNT_W (CNT_W)
   ) u_vec (
      .vec_i (io.op_in),
      .cnt_o (beat_cnt)
   );

   // Running sum plus this beat, clamped at the accumulator maximum.
   always_comb begin
      sum_wide = SUM_W'(acc_q) + SUM_W'(beat_cnt);
      if (sum_wide > ACC_MAX) begin
         acc_sat = '1;
      end else begin
         acc_sat = sum_wide[ACC_W-1:0];
      end
   end

   // Next-state and datapath updates for the three-state controller.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      acc_out_d = acc_out_q;
`ifdef POPCNT_ACC_THRESH_EN
      thresh_d  = thresh_q;
      act_d     = act_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A zero-length request has nothing to count, so it is dropped.
            if (io.start && (io.len != '0)) begin
               state_d  = ST_ACC;
               acc_d    = '0;
               rem_d    = io.len;
`ifdef POPCNT_ACC_THRESH_EN
               thresh_d = io.thresh;
`endif
            end
         end
         ST_ACC: begin
            if (io.op_valid) begin
               acc_d = acc_sat;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d   = ST_DONE;
                  acc_out_d = acc_sat;
`ifdef POPCNT_ACC_THRESH_EN
                  act_d     = (acc_sat <= thresh_q);
`endif
               end
            end
         end
         ST_DONE: begin
            if (io.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         rem_q     <= '0;
         acc_out_q <= '0;
`ifdef POPCNT_ACC_THRESH_EN
         thresh_q  <= '0;
         act_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         acc_out_q <= acc_out_d;
`ifdef POPCNT_ACC_THRESH_EN
         thresh_q  <= thresh_d;
         act_q     <= act_d;
`endif
      end
   end

   assign io.busy      = (state_q != ST_IDLE);
   assign io.out_valid = (state_q == ST_DONE);
   assign io.acc_out   = acc_out_q;
`ifdef POPCNT_ACC_THRESH_EN
   assign io.act_out   = act_q;
`endif

endmodule

// File: tb/tb_popcnt_acc.sv
// Directed self-checking bench for popcnt_acc: default widths plus a 3-bit accumulator instance.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Threshold vectors are exercised only when POPCNT_ACC_THRESH_EN is defined.
module tb_popcnt_acc;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   popcnt_acc_if #(.IN_W(2), .LEN_W(6), .ACC_W(8)) ifa ();
   popcnt_acc_if #(.IN_W(2), .LEN_W(6), .ACC_W(3)) ifb ();

   popcnt_acc #(.IN_W(2), .LEN_W(6), .ACC_W(8)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .io  (ifa.slave)
   );

   popcnt_acc #(.IN_W(2), .LEN_W(6), .ACC_W(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .io  (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check busy / out_valid / acc_out of instance A in one go.
   task automatic chk_a(input string tag, input logic b, input logic v, input logic [7:0] acc);
      chk({tag, ".busy"}, 32'(ifa.busy), 32'(b));
      chk({tag, ".out_valid"}, 32'(ifa.out_valid), 32'(v));
      chk({tag, ".acc_out"}, 32'(ifa.acc_out), 32'(acc));
   endtask

   task automatic beat_a(input logic [1:0] op, input logic vld);
      ifa.op_in    = op;
      ifa.op_valid = vld;
      tick();
   endtask

   initial begin
      logic [1:0] beats4 [4];
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      ifa.start = 1'b0; ifa.len = '0; ifa.op_in = '0; ifa.op_valid = 1'b0; ifa.out_ready = 1'b0;
      ifb.start = 1'b0; ifb.len = '0; ifb.op_in = '0; ifb.op_valid = 1'b0; ifb.out_ready = 1'b0;
`ifdef POPCNT_ACC_THRESH_EN
      ifa.thresh = 8'd0;
      ifb.thresh = 3'd0;
`endif
      tick();
      tick();
      chk_a("reset", 1'b0, 1'b0, 8'd0);
      chk("reset_b.out_valid", 32'(ifb.out_valid), 32'd0);
`ifdef POPCNT_ACC_THRESH_EN
      chk("reset.act_out", 32'(ifa.act_out), 32'd0);
`endif
      rst = 1'b0;

      // Four back-to-back beats 11,01,00,10 -> 4 mismatches.
      beats4[0] = 2'b11; beats4[1] = 2'b01; beats4[2] = 2'b00; beats4[3] = 2'b10;
      ifa.start = 1'b1; ifa.len = 6'd4;
      tick();
      ifa.start = 1'b0;
      chk_a("b2b.start", 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         beat_a(beats4[i], 1'b1);
         if (i < 3) chk_a($sformatf("b2b.beat%0d", i), 1'b1, 1'b0, 8'd0);
      end
      ifa.op_valid = 1'b0;
      chk_a("b2b.done", 1'b1, 1'b1, 8'd4);
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      chk_a("b2b.idle", 1'b0, 1'b0, 8'd4);

      // op_valid in IDLE is dropped; next vector starts from zero.
      beat_a(2'b11, 1'b1);
      chk_a("idle_beat", 1'b0, 1'b0, 8'd4);

      // Gapped beats: 11, gap, gap, 01, 10 with len=3 -> 4.
      ifa.op_valid = 1'b0;
      ifa.start = 1'b1; ifa.len = 6'd3;
      tick();
      ifa.start = 1'b0;
      beat_a(2'b11, 1'b1);
      beat_a(2'b11, 1'b0);
      beat_a(2'b11, 1'b0);
      beat_a(2'b01, 1'b1);
      chk_a("gap.pending", 1'b1, 1'b0, 8'd4);
      beat_a(2'b10, 1'b1);
      ifa.op_valid = 1'b0;
      chk_a("gap.done", 1'b1, 1'b1, 8'd4);
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;

      // DONE held 5 cycles with start asserted; result stable; start on exit ignored.
      ifa.start = 1'b1; ifa.len = 6'd1;
      tick();
      ifa.start = 1'b0;
      beat_a(2'b11, 1'b1);
      ifa.op_valid = 1'b0;
      chk_a("hold.enter", 1'b1, 1'b1, 8'd2);
      ifa.start = 1'b1; ifa.len = 6'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_a($sformatf("hold.c%0d", i), 1'b1, 1'b1, 8'd2);
      end
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      ifa.start = 1'b0;
      chk_a("hold.exit", 1'b0, 1'b0, 8'd2);
      tick();
      chk_a("hold.no_restart", 1'b0, 1'b0, 8'd2);

      // Reset after 2 of 4 beats discards the partial sum.
      ifa.start = 1'b1; ifa.len = 6'd4;
      tick();
      ifa.start = 1'b0;
      beat_a(2'b11, 1'b1);
      beat_a(2'b11, 1'b1);
      rst = 1'b1;
      ifa.out_ready = 1'b1;
      tick();
      rst = 1'b0;
      ifa.op_valid = 1'b0;
      ifa.out_ready = 1'b0;
      chk_a("midrst", 1'b0, 1'b0, 8'd0);
      ifa.start = 1'b1; ifa.len = 6'd1;
      tick();
      ifa.start = 1'b0;
      beat_a(2'b01, 1'b1);
      ifa.op_valid = 1'b0;
      chk_a("midrst.after", 1'b1, 1'b1, 8'd1);
      // Reset beats out_ready/start in DONE.
      rst = 1'b1; ifa.out_ready = 1'b1; ifa.start = 1'b1;
      tick();
      rst = 1'b0; ifa.out_ready = 1'b0; ifa.start = 1'b0;
      chk_a("donerst", 1'b0, 1'b0, 8'd0);

      // len=0 start is ignored.
      ifa.start = 1'b1; ifa.len = 6'd0;
      tick();
      ifa.start = 1'b0;
      chk_a("len0", 1'b0, 1'b0, 8'd0);
      tick();
      chk_a("len0.later", 1'b0, 1'b0, 8'd0);

      // 3-bit accumulator, five beats of 11 -> clamps at 7.
      ifb.start = 1'b1; ifb.len = 6'd5;
      tick();
      ifb.start = 1'b0;
      ifb.op_in = 2'b11; ifb.op_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) chk($sformatf("sat.pending%0d", i), 32'(ifb.out_valid), 32'd0);
      end
      ifb.op_valid = 1'b0;
      chk("sat.out_valid", 32'(ifb.out_valid), 32'd1);
      chk("sat.acc_out", 32'(ifb.acc_out), 32'd7);
      ifb.out_ready = 1'b1;
      tick();
      ifb.out_ready = 1'b0;
      chk("sat.idle", 32'(ifb.busy), 32'd0);

`ifdef POPCNT_ACC_THRESH_EN
      // thresh=2: sum 2 -> act 1 (thresh changes after start must not matter), sum 3 -> act 0.
      ifa.thresh = 8'd2;
      ifa.start = 1'b1; ifa.len = 6'd1;
      tick();
      ifa.start = 1'b0;
      ifa.thresh = 8'd0;
      beat_a(2'b11, 1'b1);
      ifa.op_valid = 1'b0;
      chk_a("thr2", 1'b1, 1'b1, 8'd2);
      chk("thr2.act_out", 32'(ifa.act_out), 32'd1);
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      ifa.thresh = 8'd2;
      ifa.start = 1'b1; ifa.len = 6'd2;
      tick();
      ifa.start = 1'b0;
      beat_a(2'b11, 1'b1);
      beat_a(2'b01, 1'b1);
      ifa.op_valid = 1'b0;
      chk_a("thr3", 1'b1, 1'b1, 8'd3);
      chk("thr3.act_out", 32'(ifa.act_out), 32'd0);
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      ifa.start = 1'b1; ifa.len = 6'd0;
      tick();
      ifa.start = 1'b0;
      chk_a("thr.len0", 1'b0, 1'b0, 8'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/popcnt_acc.md
POPCNT_ACC -- requirements
Module: popcnt_acc

Interface
REQ-001 Parameter IN_W, default 2, width of XOR bit vector per beat from the mismatch stage.
REQ-002 Parameter LEN_W, default 6, width of beat-count field.
REQ-003 Parameter ACC_W, default 8, accumulator width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a new dot-product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of beats in the vector; sampled with start.
REQ-008 op_in  input  IN_W  per-bit XOR of x and w, 1 = mismatch.
REQ-009 op_valid  input  1  op_in carries a valid beat this cycle.
REQ-010 busy  output  1  high in ACC and DONE.
REQ-011 acc_out  output  ACC_W  mismatch count of the finished vector.
REQ-012 out_valid  output  1  acc_out (and act_out) valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states IDLE, ACC, DONE; reset state IDLE.
REQ-015 IDLE: start=1 and len!=0 -> clear acc to 0, load remaining=len, enter ACC next cycle; start=1 with len=0 -> ignored, stay IDLE.
REQ-016 ACC: op_valid=1 -> acc += popcount(op_in), remaining -= 1; op_valid=0 -> hold acc and remaining.
REQ-017 ACC: beat accepted with remaining=1 -> enter DONE next cycle with final sum registered; latency from last beat to out_valid is exactly 1 cycle.
REQ-018 op_valid in IDLE or DONE is ignored; beats are never buffered.
REQ-019 Accumulation saturates at 2^ACC_W-1; no wrap-around.
REQ-020 DONE: out_valid=1, acc_out stable until out_valid&out_ready; handshake -> IDLE next cycle.
REQ-021 start in ACC or DONE is ignored, including the cycle DONE is left; a new start is honoured only from IDLE.
REQ-022 acc_out holds its last value in IDLE; out_valid=0 outside DONE.

Reset
REQ-023 rst=1 at any clock edge, including mid-ACC or in DONE, -> state IDLE, acc=0, remaining=0, acc_out=0, out_valid=0, busy=0 (act_out=0 when compiled in); partial sums discarded.
REQ-024 rst has priority over start, op_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro POPCNT_ACC_THRESH_EN compiled in: extra ports thresh input ACC_W and act_out output 1; act_out = (final acc <= thresh) registered with acc_out and valid with out_valid; thresh sampled with start.
REQ-026 Macro absent: thresh and act_out ports do not exist; all other behaviour identical.

Structure
REQ-027 Shared package holds FSM state encoding (IDLE=0, ACC=1, DONE=2) and default IN_W, LEN_W, ACC_W constants.
REQ-028 One sub-module popcnt_vec: combinational popcount of an IN_W vector to a $clog2(IN_W+1)-bit count; instantiated once.

Verification
REQ-029 rst, start len=4, beats 2'b11,2'b01,2'b00,2'b10 all valid back-to-back -> out_valid 1 cycle after 4th beat, acc_out=4, busy high throughout.
REQ-030 start len=3, beats with op_valid gaps (valid,idle,idle,valid,valid) -> acc_out equals sum of valid beats only, gaps do not count toward len.
REQ-031 ACC_W=3, len=5, all beats 2'b11 -> acc_out=7 (saturated), no wrap.
REQ-032 DONE with out_ready=0 for 5 cycles, then 1 -> acc_out stable all 6 cycles, IDLE after handshake; start asserted during DONE ignored.
REQ-033 rst asserted mid-ACC after 2 of 4 beats -> next cycle all outputs 0, IDLE; a following start len=1 beat 2'b01 -> acc_out=1.
REQ-034 POPCNT_ACC_THRESH_EN, thresh=2: vectors producing acc 2 and 3 -> act_out=1 and 0 respectively; start with len=0 -> no busy, no out_valid.
